// File: rtl/pool_row_feeder_pkg.sv
// pool_row_feeder_pkg: FSM state encodings and default sizes
// shared by the row-pair feeder and the 2x2 max-pool array.
package pool_row_feeder_pkg;

  localparam int PRF_DW      = 16;
  localparam int PRF_ROW_W   = 28;
  localparam int PRF_ROWS    = 28;
  // Must match the pool array's unit count.
  localparam int PRF_MAX_NUM = 15;

  typedef enum logic [1:0] {
    S_EVEN,
    S_ODD,
    S_POOL,
    S_OUT
  } state_e;

endpackage

// File: rtl/pool_row_feeder_row_pair_buf.sv
// row_pair_buf: even/odd feature-map row registers.
// Ports: clk, rst, ld_even_i, ld_odd_i, row_i, pair_o ({odd,even}).
module row_pair_buf
  import pool_row_feeder_pkg::*;
#(
  parameter int DW    = PRF_DW,
  parameter int ROW_W = PRF_ROW_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_even_i,
  input  logic                    ld_odd_i,
  input  logic [ROW_W*DW-1:0]     row_i,
  output logic [2*ROW_W*DW-1:0]   pair_o
);

  localparam int RW = ROW_W * DW;

  logic [RW-1:0] even_q;
  logic [RW-1:0] odd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      even_q <= '0;
      odd_q  <= '0;
    end else begin
      if (ld_even_i) even_q <= row_i;
      if (ld_odd_i)  odd_q  <= row_i;
    end
  end

  assign pair_o = {odd_q, even_q};

endmodule

// File: rtl/pool_row_feeder.sv
// pool_row_feeder: pairs conv rows, fires the pool array, emits
// pooled rows. Ports: in_* row stream, fm_out/max_en/pool_result
// to the pool array, out_* pooled stream, frame_done pulse.
module pool_row_feeder
  import pool_row_feeder_pkg::*;
#(
  parameter int DW       = PRF_DW,
  parameter int ROW_W    = PRF_ROW_W,
  parameter int ROWS     = PRF_ROWS,
  parameter int MAX_NUM  = PRF_MAX_NUM,
  parameter int POOL_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROW_W*DW-1:0]           in_row,
  output logic [2*ROW_W*DW-1:0]         fm_out,
  output logic [MAX_NUM-1:0]            max_en,
  input  logic [MAX_NUM*DW-1:0]         pool_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(ROW_W/2)*DW-1:0]       out_row,
  output logic                          out_last,
  output logic                          frame_done
);

  localparam int HALF  = ROW_W / 2;
  localparam int HW    = HALF * DW;
  localparam int LASTP = ROWS / 2 - 1;
  localparam int PW    = (ROWS / 2 > 1) ? $clog2(ROWS / 2) : 1;

  state_e             state_q;
  logic [1:0]         lat_q;
  logic [PW-1:0]      pair_q;
  logic [MAX_NUM-1:0] max_en_q;
  logic [HW-1:0]      out_row_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic               frame_done_q;

  logic [MAX_NUM-1:0] en_mask;
  logic               acc;
  logic               last_pair;
  logic               unused_pool;

  always_comb begin
    en_mask = '0;
    for (int i = 0; i < HALF; i++) begin
      en_mask[i] = 1'b1;
    end
  end

  // rst wins over any handshake in the same cycle.
  assign in_ready  = !rst &&
                     (state_q == S_EVEN ||
                      state_q == S_ODD);
  assign acc       = in_valid && in_ready;
  assign last_pair = (pair_q == PW'(LASTP));

  // Units beyond ROW_W/2 are never enabled.
  assign unused_pool = ^pool_result;

  row_pair_buf #(
    .DW    (DW),
    .ROW_W (ROW_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .ld_even_i (acc && state_q == S_EVEN),
    .ld_odd_i  (acc && state_q == S_ODD),
    .row_i     (in_row),
    .pair_o    (fm_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EVEN;
      lat_q        <= '0;
      pair_q       <= '0;
      max_en_q     <= '0;
      out_row_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      max_en_q     <= '0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        S_EVEN: begin
          if (in_valid) state_q <= S_ODD;
        end
        S_ODD: begin
          if (in_valid) begin
            state_q  <= S_POOL;
            max_en_q <= en_mask;
            lat_q    <= 2'(POOL_LAT);
          end
        end
        S_POOL: begin
          // Counter hits 0 POOL_LAT cycles after max_en.
          if (lat_q == 2'd0) begin
            out_row_q   <= pool_result[HW-1:0];
            out_valid_q <= 1'b1;
            out_last_q  <= last_pair;
            state_q     <= S_OUT;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= last_pair;
            pair_q       <= last_pair ? '0
                                      : pair_q + 1'b1;
            state_q      <= S_EVEN;
          end
        end
        default: state_q <= S_EVEN;
      endcase
    end
  end

  assign max_en     = max_en_q;
  assign out_row    = out_row_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_row_feeder.sv
// tb_pool_row_feeder: scoreboard bench for pool_row_feeder
// with a behavioural pool array; second instance uses POOL_LAT=3.
module tb_pool_row_feeder;

  localparam int DW      = 16;
  localparam int ROW_W   = 28;
  localparam int ROWS    = 28;
  localparam int MAX_NUM = 15;
  localparam int RW      = ROW_W * DW;
  localparam int FW      = 2 * RW;
  localparam int HW      = (ROW_W / 2) * DW;
  localparam int PRW     = MAX_NUM * DW;
  localparam int LASTP   = ROWS / 2 - 1;
  localparam logic [MAX_NUM-1:0] MASK = 15'h3FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [RW-1:0]     in_row = '0;
  logic [FW-1:0]     fm_out;
  logic [MAX_NUM-1:0] max_en;
  logic [PRW-1:0]    pool_result;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [HW-1:0]     out_row;
  logic              out_last;
  logic              frame_done;

  logic              in_valid3 = 1'b0;
  logic              in_ready3;
  logic [RW-1:0]     in_row3 = '0;
  logic [FW-1:0]     fm_out3;
  logic [MAX_NUM-1:0] max_en3;
  logic [PRW-1:0]    pool_result3 = '0;
  logic              out_valid3;
  logic              out_ready3 = 1'b0;
  logic [HW-1:0]     out_row3;
  logic              out_last3;
  logic              frame_done3;

  pool_row_feeder #(
    .DW(DW), .ROW_W(ROW_W), .ROWS(ROWS),
    .MAX_NUM(MAX_NUM), .POOL_LAT(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .fm_out(fm_out),
    .max_en(max_en), .pool_result(pool_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_last(out_last),
    .frame_done(frame_done)
  );

  pool_row_feeder #(
    .DW(DW), .ROW_W(ROW_W), .ROWS(ROWS),
    .MAX_NUM(MAX_NUM), .POOL_LAT(3)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .in_row(in_row3), .fm_out(fm_out3),
    .max_en(max_en3), .pool_result(pool_result3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_row(out_row3), .out_last(out_last3),
    .frame_done(frame_done3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] pool2(
      input logic [RW-1:0] e, input logic [RW-1:0] o);
    logic [DW-1:0] m;
    logic [HW-1:0] r;
    r = '0;
    for (int j = 0; j < ROW_W / 2; j++) begin
      m = e[2*j*DW +: DW];
      if (e[(2*j+1)*DW +: DW] > m) m = e[(2*j+1)*DW +: DW];
      if (o[2*j*DW +: DW] > m)     m = o[2*j*DW +: DW];
      if (o[(2*j+1)*DW +: DW] > m) m = o[(2*j+1)*DW +: DW];
      r[j*DW +: DW] = m;
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] mk_row(input int base);
    logic [RW-1:0] r;
    for (int k = 0; k < ROW_W; k++) r[k*DW +: DW] = DW'(base + k);
    return r;
  endfunction

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] r;
    for (int k = 0; k < ROW_W; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Behavioural pool array, latency 1; garbage when not valid.
  logic          pv_q;
  logic [HW-1:0] pd_q;
  always @(posedge clk) begin
    pv_q <= max_en[0];
    pd_q <= pool2(fm_out[RW-1:0], fm_out[FW-1:RW]);
  end
  assign pool_result = {16'hBEEF, pv_q ? pd_q : ~pd_q};

  typedef struct {
    logic [HW-1:0] row;
    logic          last;
  } exp_t;

  exp_t          q[$];
  logic [RW-1:0] even_m, odd_m;
  bit            par = 0;
  int            pair_m = 0;
  bit            men_pend = 0;
  bit            fd_pend = 0;
  int            out_cnt = 0, last_cnt = 0;
  int            fd_cnt = 0, men_cnt = 0;

  always @(negedge clk) begin
    bit   men_n, fd_n;
    exp_t e;
    men_n = 0;
    fd_n  = 0;
    if (max_en != '0 || men_pend) begin
      chk("max_en", max_en, men_pend ? MASK : '0);
      if (men_pend) begin
        chk("fm_even", fm_out[RW-1:0], even_m);
        chk("fm_odd", fm_out[FW-1:RW], odd_m);
      end
    end
    if (frame_done || fd_pend) chk("frame_done", frame_done, fd_pend);
    if (frame_done) fd_cnt++;
    if (max_en != '0) men_cnt++;
    if (rst) begin
      q.delete();
      par    = 0;
      pair_m = 0;
    end else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (out_last) last_cnt++;
        chk("out_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_row", out_row, e.row);
          chk("out_last", out_last, e.last);
          fd_n = e.last;
        end
      end
      if (in_valid && in_ready) begin
        if (!par) begin
          even_m = in_row;
        end else begin
          odd_m = in_row;
          e.row  = pool2(even_m, in_row);
          e.last = (pair_m == LASTP);
          q.push_back(e);
          pair_m = (pair_m == LASTP) ? 0 : pair_m + 1;
          men_n  = 1;
        end
        par = !par;
      end
    end
    men_pend = men_n;
    fd_pend  = fd_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [RW-1:0] r);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_row   = r;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("in_ready_wait", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain", q.size(), 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] e, o;
    logic [HW-1:0] pexp;
    int c0, l0, f0, m0, n;

    // Reset state
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_max_en", max_en, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_out_row", out_row, '0);
    chk("rst_fm_even", fm_out[RW-1:0], '0);
    chk("rst_fm_odd", fm_out[FW-1:RW], '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    tick();

    // Single pair with latency check
    m0 = men_cnt;
    send(mk_row(0));
    send(mk_row(100));
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("lat_out_valid", out_valid, i == 3);
      if (i == 3) chk("single_row", out_row, pool2(mk_row(0), mk_row(100)));
      @(posedge clk);
      #1;
    end
    drain();
    chk("single_men_cnt", men_cnt - m0, 1);

    // Two back-to-back full frames
    do_reset();
    c0 = out_cnt;
    l0 = last_cnt;
    f0 = fd_cnt;
    for (int r = 0; r < 2 * ROWS; r++) send(rnd_row());
    drain();
    chk("frames_out_cnt", out_cnt - c0, ROWS);
    chk("frames_last_cnt", last_cnt - l0, 2);
    chk("frames_fd_cnt", fd_cnt - f0, 2);

    // Output backpressure
    out_ready = 1'b0;
    e = rnd_row();
    o = rnd_row();
    pexp = pool2(e, o);
    send(e);
    send(o);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("bp_valid_wait", out_valid, 1'b1);
    @(posedge clk);
    #1;
    m0 = men_cnt;
    in_valid = 1'b1;
    in_row = rnd_row();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_row", out_row, pexp);
      chk("bp_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("bp_men_cnt", men_cnt - m0, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Random gaps between even and odd rows
    for (int p = 0; p < 4; p++) begin
      send(rnd_row());
      idle($urandom_range(0, 4));
      send(rnd_row());
      idle($urandom_range(0, 3));
    end
    drain();

    // Reset while pooling pair 7
    do_reset();
    for (int p = 0; p < 6; p++) begin
      send(rnd_row());
      send(rnd_row());
    end
    drain();
    send(rnd_row());
    send(rnd_row());
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_max_en", max_en, '0);
    @(posedge clk);
    #1;
    c0 = out_cnt;
    l0 = last_cnt;
    f0 = fd_cnt;
    for (int r = 0; r < ROWS; r++) send(rnd_row());
    drain();
    chk("midrst_out_cnt", out_cnt - c0, ROWS / 2);
    chk("midrst_last_cnt", last_cnt - l0, 1);
    chk("midrst_fd_cnt", fd_cnt - f0, 1);

    // POOL_LAT=3 instance: sample exactly at T+4
    e = rnd_row();
    o = rnd_row();
    pexp = pool2(e, o);
    in_valid3 = 1'b1;
    in_row3 = e;
    @(negedge clk);
    chk("l3_rdy_even", in_ready3, 1'b1);
    tick();
    in_row3 = o;
    @(negedge clk);
    chk("l3_rdy_odd", in_ready3, 1'b1);
    tick();
    in_valid3 = 1'b0;
    pool_result3 = {16'h0, ~pexp};
    @(negedge clk);
    chk("l3_max_en", max_en3, MASK);
    chk("l3_fm_even", fm_out3[RW-1:0], e);
    chk("l3_fm_odd", fm_out3[FW-1:RW], o);
    tick();
    @(negedge clk);
    chk("l3_valid_t2", out_valid3, 1'b0);
    tick();
    tick();
    pool_result3 = {16'h0, pexp};
    @(negedge clk);
    chk("l3_valid_t4", out_valid3, 1'b0);
    tick();
    pool_result3 = {16'h0, pexp ^ {HW{1'b1}}};
    @(negedge clk);
    chk("l3_valid_t5", out_valid3, 1'b1);
    chk("l3_row_t5", out_row3, pexp);
    tick();
    @(negedge clk);
    chk("l3_row_t6", out_row3, pexp);
    chk("l3_last", out_last3, 1'b0);
    @(posedge clk);
    #1;
    out_ready3 = 1'b1;
    tick();
    @(negedge clk);
    chk("l3_drained", out_valid3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
